sp_unit_arbiter: RTL and testbench
==================================

# sp_unit_arbiter

Shares one multi-cycle special-purpose (SP) execution datapath between `NUM_REQ` requesters. Each requester presents a `taiga_types::sp_inputs_t` operand packet and an `id_t` tag. The arbiter grants requesters round-robin, issues one operation at a time to the datapath, and supervises completion with a watchdog. It returns the tagged result to the owning requester and supports pipeline flush.

## Interface

Parameters:
- `NUM_REQ`, 4: number of requesters; must be at least 2.
- `TIMEOUT`, 256: maximum cycles allowed in WAIT before an error response; must be at least 2.
- `ID_W`, `$clog2(MAX_IDS)`: tag width, equal to the `id_t` width.

Ports:
- `clk`, in, 1: the only clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `flush`, in, 1: kills the operation in progress.
- `req_valid`, in, NUM_REQ: request pending, one bit per requester.
- `req_inputs`, in, NUM_REQ×78: `sp_inputs_t` per requester; requester i occupies slice `[78*i +: 78]`.
- `req_id`, in, NUM_REQ×ID_W: tag per requester.
- `req_ready`, out, NUM_REQ: one-hot grant pulse.
- `sp_start`, out, 1: operation valid to the datapath.
- `sp_inputs`, out, 78: latched operand packet.
- `sp_ready`, in, 1: datapath accepts `sp_start`.
- `sp_done`, in, 1: single-cycle completion pulse.
- `sp_result`, in, 32: result, valid with `sp_done`.
- `rsp_valid`, out, 1: response available.
- `rsp_owner`, out, `$clog2(NUM_REQ)`: index of the owning requester.
- `rsp_id`, out, ID_W: echoed tag.
- `rsp_data`, out, 32: result.
- `rsp_error`, out, 1: set when the watchdog expired.
- `rsp_ready`, in, 1: response consumed.
- `busy`, out, 1: set whenever the state is not IDLE.

## Operation

- The FSM has four states: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- **IDLE:**
  - If `flush` is high, stay in IDLE and grant nothing.
  - Otherwise, if any `req_valid` is set, pick the first set bit scanning upward from `last_grant+1`, with modulo wrap.
  - Drive `req_ready[sel]`=1 in the same cycle. The grant is combinational from `req_valid` and is asserted in IDLE only.
  - Latch `req_inputs[sel]`, `req_id[sel]`, owner=`sel`, and `last_grant`=`sel`. Go to ISSUE.
- **ISSUE:**
  - `sp_start`=1 and `sp_inputs` = the latched packet. `sp_start` is held until `sp_ready`.
  - On `sp_start && sp_ready`: clear the watchdog counter and go to WAIT.
  - `flush` while in ISSUE: drop `sp_start` and go to IDLE. Nothing was issued.
  - `sp_done` while in ISSUE is a protocol error and is ignored.
- **WAIT:**
  - The watchdog counter increments each cycle. It is `$clog2(TIMEOUT)+1` bits wide and saturates.
  - On `sp_done`: latch `sp_result` into `rsp_data`, set `rsp_error`=0, go to RESP.
  - If the counter equals `TIMEOUT-1` and `sp_done` is low: set `rsp_data`=0, `rsp_error`=1, go to RESP.
  - If `sp_done` and the timeout coincide, `sp_done` wins.
  - `flush` in WAIT sets the sticky `killed` flag. The FSM stays in WAIT until `sp_done` or timeout, because the datapath must drain. It then goes to IDLE with no response and clears `killed`.
- **RESP:**
  - `rsp_valid`=1; `rsp_owner`, `rsp_id`, `rsp_data`, `rsp_error` are held stable.
  - On `rsp_ready`: go to IDLE.
  - `flush` in RESP: drop `rsp_valid` and go to IDLE. If `flush` and `rsp_ready` arrive in the same cycle, `flush` wins; treat the response as discarded.
- Only one operation is in flight at any time.

## Timing

- **Reset values:** `req_ready`=0, `sp_start`=0, `sp_inputs`=0, `rsp_valid`=0, `rsp_owner`=0, `rsp_id`=0, `rsp_data`=0, `rsp_error`=0, `busy`=0. `last_grant` resets to `NUM_REQ-1` so requester 0 wins first. `killed`=0, watchdog=0.
- All outputs except `req_ready` are registers or decoded from registers. There is no combinational path from `sp_*` or `rsp_ready` to any output.
- **Latency:**
  - Grant at cycle 0.
  - `sp_start` at cycle 1.
  - If `sp_ready` at cycle 1, WAIT begins at cycle 2.
  - `sp_done` at cycle k (k≥2) gives `rsp_valid` at k+1.
  - After the `rsp_ready` handshake at cycle r, the next grant occurs at r+1 at the earliest.
- **Timeout:** with no `sp_done`, `rsp_valid` with `rsp_error` rises exactly `TIMEOUT+1` cycles after the issue handshake cycle.
- **Reset mid-operation:** asynchronous reset returns everything to the reset values immediately, in any state. Round-robin state is lost.

## Test plan

- **Single request:** `req_valid`=4'b0001, `sp_ready`=1, `sp_done` 3 cycles after issue with `sp_result`=32'hDEADBEEF, `req_id`=5 -> `req_ready[0]` at cycle 0; `sp_start` for exactly 1 cycle; `rsp_valid` with owner 0, id 5, data DEADBEEF, error 0.
- **Fairness:** all four requesters continuously valid over 8 operations -> grant order 0,1,2,3,0,1,2,3.
- **Backpressure:** `sp_ready` low for 5 cycles, then `rsp_ready` low for 4 cycles -> `sp_start` and `sp_inputs` stable for 6 cycles; response fields stable while `rsp_valid` is high; no second grant.
- **Watchdog:** `TIMEOUT`=8, `sp_done` never asserted -> `rsp_valid`, `rsp_error`=1, `rsp_data`=0 exactly 9 cycles after the issue handshake. Repeat with `sp_done` on the timeout cycle -> `rsp_error`=0.
- **Flush:**
  - `flush` in WAIT, `sp_done` 4 cycles later -> no `rsp_valid`; IDLE the next cycle.
  - `flush` in ISSUE -> `sp_start` deasserts the next cycle.
  - `flush` coinciding with `req_valid` in IDLE -> no grant.
- **Async reset:** `rst_n` low during RESP -> all outputs 0 without waiting for a clock edge. After release, requester 0 is granted first.

Source files
------------

// File: rtl/sp_unit_arbiter.sv
// Round-robin arbiter sharing one multi-cycle SP datapath between NUM_REQ requesters,
// with a completion watchdog, tagged response return and flush handling.
//
// state | meaning
// IDLE  | no operation owned; combinational round-robin grant
// ISSUE | latched packet presented with sp_start until sp_ready
// WAIT  | operation in flight; watchdog running; drains even when killed
// RESP  | response held on rsp_* until rsp_ready or flush
module sp_unit_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 256,
  parameter int MAX_IDS = 8,
  parameter int ID_W    = $clog2(MAX_IDS),
  localparam int SP_W   = 78,
  localparam int OW     = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*SP_W-1:0] req_inputs,
  input  logic [NUM_REQ*ID_W-1:0] req_id,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    sp_start,
  output logic [SP_W-1:0]         sp_inputs,
  input  logic                    sp_ready,
  input  logic                    sp_done,
  input  logic [31:0]             sp_result,
  output logic                    rsp_valid,
  output logic [OW-1:0]           rsp_owner,
  output logic [ID_W-1:0]         rsp_id,
  output logic [31:0]             rsp_data,
  output logic                    rsp_error,
  input  logic                    rsp_ready,
  output logic                    busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

  logic [1:0]      state;
  logic [OW-1:0]   last_grant;
  logic [CW-1:0]   wd_count;
  logic            killed;

  logic            grant_found;
  logic [OW-1:0]   grant_idx;
  logic [OW-1:0]   cand;
  logic [SP_W-1:0] sel_inputs;
  logic [ID_W-1:0] sel_id;
  logic            timeout_hit;

  // Scan upward from the requester after the last winner, wrapping modulo NUM_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = OW'((int'(last_grant) + i) % NUM_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    sel_inputs = '0;
    sel_id     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == OW'(i)) begin
        sel_inputs = req_inputs[i*SP_W +: SP_W];
        sel_id     = req_id[i*ID_W +: ID_W];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == S_IDLE && !flush && grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign timeout_hit = (wd_count == WD_LAST);
  assign sp_start    = (state == S_ISSUE);
  assign rsp_valid   = (state == S_RESP);
  assign busy        = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      last_grant <= OW'(NUM_REQ - 1);
      wd_count   <= '0;
      killed     <= 1'b0;
      sp_inputs  <= '0;
      rsp_owner  <= '0;
      rsp_id     <= '0;
      rsp_data   <= '0;
      rsp_error  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!flush && grant_found) begin
            sp_inputs  <= sel_inputs;
            rsp_id     <= sel_id;
            rsp_owner  <= grant_idx;
            last_grant <= grant_idx;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (flush) begin
            state <= S_IDLE;
          end else if (sp_ready) begin
            wd_count <= '0;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wd_count != '1) begin
            wd_count <= wd_count + 1'b1;
          end
          if (flush) begin
            killed <= 1'b1;
          end
          // A killed operation still waits here so the datapath drains before reuse.
          if (sp_done || timeout_hit) begin
            killed <= 1'b0;
            if (killed || flush) begin
              state <= S_IDLE;
            end else begin
              rsp_data  <= sp_done ? sp_result : 32'd0;
              rsp_error <= !sp_done;
              state     <= S_RESP;
            end
          end
        end
        default: begin
          if (flush || rsp_ready) begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sp_unit_arbiter.sv
// Self-checking bench for sp_unit_arbiter: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a transaction-level model.
module tb_sp_unit_arbiter;

  localparam int NUM_REQ = 4;
  localparam int TIMEOUT = 8;
  localparam int ID_W    = 3;
  localparam int SP_W    = 78;
  localparam int OW      = 2;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    flush;
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ*SP_W-1:0] req_inputs;
  logic [NUM_REQ*ID_W-1:0] req_id;
  logic [NUM_REQ-1:0]      req_ready;
  logic                    sp_start;
  logic [SP_W-1:0]         sp_inputs;
  logic                    sp_ready;
  logic                    sp_done;
  logic [31:0]             sp_result;
  logic                    rsp_valid;
  logic [OW-1:0]           rsp_owner;
  logic [ID_W-1:0]         rsp_id;
  logic [31:0]             rsp_data;
  logic                    rsp_error;
  logic                    rsp_ready;
  logic                    busy;

  always #5 clk = ~clk;

  sp_unit_arbiter #(
    .NUM_REQ(NUM_REQ),
    .TIMEOUT(TIMEOUT),
    .MAX_IDS(8),
    .ID_W(ID_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_inputs(req_inputs), .req_id(req_id), .req_ready(req_ready),
    .sp_start(sp_start), .sp_inputs(sp_inputs), .sp_ready(sp_ready), .sp_done(sp_done),
    .sp_result(sp_result), .rsp_valid(rsp_valid), .rsp_owner(rsp_owner), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_error(rsp_error), .rsp_ready(rsp_ready), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  // Transaction-level model: one operation record and where it is in its lifetime.
  int              m_last;
  bit              m_pend, m_flight, m_held, m_killed;
  int              m_hs, cyc;
  logic [SP_W-1:0] m_inputs;
  logic [ID_W-1:0] m_id;
  int              m_owner;
  logic [31:0]     m_data;
  bit              m_err;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_last = NUM_REQ - 1;
    m_pend = 0; m_flight = 0; m_held = 0; m_killed = 0;
    m_hs = 0; cyc = 0;
    m_inputs = '0; m_id = '0; m_owner = 0; m_data = '0; m_err = 0;
  endfunction

  function automatic int pick();
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (req_valid[(m_last + i) % NUM_REQ]) return (m_last + i) % NUM_REQ;
    end
    return -1;
  endfunction

  function automatic logic [NUM_REQ-1:0] exp_grant();
    logic [NUM_REQ-1:0] g;
    int p;
    g = '0;
    p = pick();
    if (!(m_pend || m_flight || m_held) && !flush && p >= 0) g[p] = 1'b1;
    return g;
  endfunction

  task automatic compare_model();
    chk("req_ready", req_ready, exp_grant());
    chk("sp_start", sp_start, m_pend);
    chk("busy", busy, m_pend || m_flight || m_held);
    chk("rsp_valid", rsp_valid, m_held);
    if (m_pend) chk("sp_inputs", sp_inputs, m_inputs);
    if (m_held) begin
      chk("rsp_owner", rsp_owner, m_owner);
      chk("rsp_id", rsp_id, m_id);
      chk("rsp_data", rsp_data, m_data);
      chk("rsp_error", rsp_error, m_err);
    end
  endtask

  task automatic model_update();
    int g;
    if (!(m_pend || m_flight || m_held)) begin
      g = pick();
      if (!flush && g >= 0) begin
        m_last   = g;
        m_owner  = g;
        m_inputs = req_inputs[g*SP_W +: SP_W];
        m_id     = req_id[g*ID_W +: ID_W];
        m_pend   = 1;
      end
    end else if (m_pend) begin
      if (flush) m_pend = 0;
      else if (sp_ready) begin
        m_pend = 0; m_flight = 1; m_hs = cyc; m_killed = 0;
      end
    end else if (m_flight) begin
      if (sp_done || (cyc - m_hs == TIMEOUT)) begin
        m_flight = 0;
        if (!(m_killed || flush)) begin
          m_held = 1;
          m_data = sp_done ? sp_result : 32'd0;
          m_err  = !sp_done;
        end
        m_killed = 0;
      end else if (flush) m_killed = 1;
    end else if (m_held) begin
      if (flush || rsp_ready) m_held = 0;
    end
    cyc++;
  endtask

  task automatic step();
    #1;
    compare_model();
    model_update();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    flush = 0; req_valid = '0; sp_ready = 0; sp_done = 0; sp_result = '0; rsp_ready = 0;
  endtask

  task automatic rand_packets();
    logic [95:0] t;
    for (int i = 0; i < NUM_REQ; i++) begin
      t = {$urandom, $urandom, $urandom};
      req_inputs[i*SP_W +: SP_W] = t[SP_W-1:0];
      req_id[i*ID_W +: ID_W] = ID_W'($urandom_range(0, 7));
    end
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  // Grant requester 0 and complete the issue handshake; returns at the first WAIT cycle.
  task automatic issue_req0();
    req_valid = 4'b0001; sp_ready = 1;
    step();
    req_valid = '0;
    step();
    sp_ready = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, limit 1000000 ns");
    $fatal(1);
  end

  initial begin
    logic [SP_W-1:0]    pkt;
    logic [ID_W-1:0]    id0;
    logic [31:0]        r;
    int                 order[8];
    int                 n, n_start;

    req_inputs = '0; req_id = '0;
    do_reset();
    #1;
    chk("reset_req_ready", req_ready, 0);
    chk("reset_sp_start", sp_start, 0);
    chk("reset_sp_inputs", sp_inputs, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_fields", {rsp_owner, rsp_id, rsp_data, rsp_error}, 0);
    chk("reset_busy", busy, 0);
    @(negedge clk);

    // Single request
    rand_packets();
    req_id[ID_W-1:0] = 3'd5;
    req_valid = 4'b0001; sp_ready = 1;
    #1 chk("single_grant", req_ready, 4'b0001);
    step();
    req_valid = '0;
    #1 chk("single_start", sp_start, 1);
    step();
    sp_ready = 0;
    #1 chk("single_start_once", sp_start, 0);
    step();
    step();
    sp_done = 1; sp_result = 32'hDEADBEEF;
    step();
    sp_done = 0;
    #1;
    chk("single_rsp_valid", rsp_valid, 1);
    chk("single_rsp_owner", rsp_owner, 0);
    chk("single_rsp_id", rsp_id, 5);
    chk("single_rsp_data", rsp_data, 32'hDEADBEEF);
    chk("single_rsp_error", rsp_error, 0);
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    #1 chk("single_idle", busy, 0);
    step();

    // Fairness
    do_reset();
    req_valid = 4'hF; sp_ready = 1; sp_done = 1; rsp_ready = 1;
    n = 0;
    for (int c = 0; c < 200 && n < 8; c++) begin
      #1;
      for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) order[n] = i;
      if (req_ready != 0) n++;
      step();
    end
    chk("fair_count", n, 8);
    for (int i = 0; i < 8; i++) chk("fair_order", order[i], i % NUM_REQ);

    // Backpressure
    do_reset();
    rand_packets();
    pkt = req_inputs[SP_W-1:0];
    id0 = req_id[ID_W-1:0];
    req_valid = 4'b0001;
    #1 chk("bp_grant", req_ready, 4'b0001);
    step();
    n_start = 0;
    for (int i = 0; i < 6; i++) begin
      rand_packets();
      sp_ready = (i == 5);
      #1;
      if (sp_start) n_start++;
      chk("bp_inputs", sp_inputs, pkt);
      chk("bp_no_grant", req_ready, 0);
      step();
    end
    chk("bp_start_cycles", n_start, 6);
    sp_ready = 0; sp_done = 1; r = $urandom; sp_result = r;
    step();
    sp_done = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_stable", {rsp_owner, rsp_id, rsp_data}, {2'd0, id0, r});
      chk("bp_no_grant2", req_ready, 0);
      step();
    end
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    #1 chk("bp_regrant", req_ready, 4'b0001);
    step();

    // Watchdog: no completion
    do_reset();
    issue_req0();
    n = 1;
    while (!rsp_valid && n < 20) begin
      step();
      n++;
    end
    chk("wd_latency", n, TIMEOUT + 1);
    chk("wd_error", rsp_error, 1);
    chk("wd_data", rsp_data, 0);
    rsp_ready = 1;
    step();
    rsp_ready = 0;

    // Watchdog: completion on the timeout cycle wins
    do_reset();
    issue_req0();
    repeat (TIMEOUT - 1) step();
    sp_done = 1; sp_result = 32'h1234_5678;
    step();
    sp_done = 0;
    #1;
    chk("wd_done_valid", rsp_valid, 1);
    chk("wd_done_error", rsp_error, 0);
    chk("wd_done_data", rsp_data, 32'h1234_5678);
    rsp_ready = 1;
    step();
    rsp_ready = 0;

    // Flush in WAIT drains without a response
    do_reset();
    issue_req0();
    flush = 1;
    step();
    flush = 0;
    repeat (3) step();
    sp_done = 1; sp_result = 32'hCAFE;
    step();
    sp_done = 0;
    #1;
    chk("flush_wait_no_rsp", rsp_valid, 0);
    chk("flush_wait_idle", busy, 0);
    step();

    // Flush in ISSUE
    do_reset();
    req_valid = 4'b0001;
    step();
    req_valid = '0; flush = 1;
    #1 chk("flush_issue_start", sp_start, 1);
    step();
    flush = 0;
    #1;
    chk("flush_issue_drop", sp_start, 0);
    chk("flush_issue_idle", busy, 0);
    step();

    // Flush in IDLE blocks the grant
    flush = 1; req_valid = 4'hF;
    #1 chk("flush_idle_nogrant", req_ready, 0);
    step();
    flush = 0; req_valid = '0;
    #1 chk("flush_idle_busy", busy, 0);
    step();

    // Asynchronous reset during RESP
    do_reset();
    req_valid = 4'b0010;
    sp_ready = 1;
    step();
    req_valid = '0;
    step();
    sp_ready = 0; sp_done = 1; sp_result = 32'hFFFF_FFFF;
    step();
    sp_done = 0;
    #1 chk("areset_in_resp", rsp_valid, 1);
    #1 rst_n = 0;
    #1;
    chk("areset_outputs", {req_ready, sp_start, sp_inputs, rsp_valid}, 0);
    chk("areset_rsp", {rsp_owner, rsp_id, rsp_data, rsp_error, busy}, 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
    req_valid = 4'hF;
    #1 chk("areset_first_grant", req_ready, 4'b0001);
    step();

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rand_packets();
      req_valid = NUM_REQ'($urandom);
      flush     = ($urandom_range(0, 15) == 0);
      sp_ready  = ($urandom_range(0, 3) != 0);
      sp_done   = ($urandom_range(0, 3) == 0);
      sp_result = $urandom;
      rsp_ready = $urandom_range(0, 1) == 1;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
